bullet_sprite_reader: RTL and testbench

// Read side of the bullet sprite ROM (SPRITE_W x SPRITE_H, 4-bit palette indices, 1-cycle read latency).

---
 rtl/bullet_sprite_reader.sv | 168 ++++++++++++++++
 tb/tb_bullet_sprite_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_sprite_reader.sv
// bullet_sprite_reader: read side of the bullet sprite ROM.
// Hit-tests each scanned pixel against the latched bullet box, issues the ROM read address,
// absorbs the 1-cycle ROM latency and delivers an aligned palette index and opaque flag
// three cycles after the pixel was presented. Also counts opaque pixels per frame.
// Optional feature: define BULLET_MIRROR_EN to flip the sprite horizontally when the
// latched dir_left is set. Without it dir_left is accepted but ignored.
module bullet_sprite_reader #(
  parameter int unsigned      SPRITE_W        = 20,
  parameter int unsigned      SPRITE_H        = 20,
  parameter int unsigned      COORD_W         = 10,
  parameter int unsigned      ADDR_W          = 19,
  parameter int unsigned      PIX_W           = 4,
  parameter logic [PIX_W-1:0] TRANSPARENT_IDX = '0
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic [COORD_W-1:0] BulletX,
  input  logic [COORD_W-1:0] BulletY,
  input  logic               bullet_active,
  input  logic               dir_left,
  output logic [ADDR_W-1:0]  read_address,
  input  logic [PIX_W-1:0]   rom_data,
  output logic               pix_out_valid,
  output logic               bullet_on,
  output logic [PIX_W-1:0]   palette_idx,
  output logic [15:0]        opaque_count
);

  // Box extents are compared one bit wider than the screen so sX+SPRITE_W cannot wrap.
  localparam logic [COORD_W:0]   SprWExt   = (COORD_W+1)'(SPRITE_W);
  localparam logic [COORD_W:0]   SprHExt   = (COORD_W+1)'(SPRITE_H);
  localparam logic [ADDR_W-1:0]  RowStride = ADDR_W'(SPRITE_W);
`ifdef BULLET_MIRROR_EN
  localparam logic [COORD_W-1:0] SprWLast  = COORD_W'(SPRITE_W - 1);
`endif

  // Frame-stable copy of the game-logic bullet state.
  logic [COORD_W-1:0] shadow_x_q;
  logic [COORD_W-1:0] shadow_y_q;
  logic               shadow_active_q;
`ifdef BULLET_MIRROR_EN
  logic               shadow_dir_q;
`else
  logic               unused_dir;
  assign unused_dir = dir_left;
`endif

  // Pipeline bookkeeping.
  logic s1_valid_q;
  logic s1_hit_q;
  logic s2_valid_q;
  logic s2_hit_q;

  // Opaque pixel counter for the frame in progress.
  logic [15:0] counter_q;

  // Stage-1 combinational hit test and address generation.
  logic [COORD_W:0]   dx_ext;
  logic [COORD_W:0]   dy_ext;
  logic [COORD_W:0]   sx_ext;
  logic [COORD_W:0]   sy_ext;
  logic               hit;
  logic [COORD_W-1:0] col_raw;
  logic [COORD_W-1:0] col;
  logic [COORD_W-1:0] row;
  logic [ADDR_W-1:0]  addr_next;

  assign dx_ext = {1'b0, DrawX};
  assign dy_ext = {1'b0, DrawY};
  assign sx_ext = {1'b0, shadow_x_q};
  assign sy_ext = {1'b0, shadow_y_q};

  assign hit = shadow_active_q
             & (dx_ext >= sx_ext) & (dx_ext < (sx_ext + SprWExt))
             & (dy_ext >= sy_ext) & (dy_ext < (sy_ext + SprHExt));

  // Offsets are only meaningful on a hit, where they are always inside the sprite.
  assign col_raw = DrawX - shadow_x_q;
  assign row     = DrawY - shadow_y_q;

`ifdef BULLET_MIRROR_EN
  assign col = shadow_dir_q ? (SprWLast - col_raw) : col_raw;
`else
  assign col = col_raw;
`endif

  assign addr_next = (ADDR_W'(row) * RowStride) + ADDR_W'(col);

  // Stage-3 decision: the ROM word for the stage-2 pixel is on rom_data this cycle.
  logic bullet_on_next;
  assign bullet_on_next = s2_valid_q & s2_hit_q & (rom_data != TRANSPARENT_IDX);

  // Latch bullet state only at frame start so a frame never tears mid-scan.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      shadow_x_q      <= '0;
      shadow_y_q      <= '0;
      shadow_active_q <= 1'b0;
`ifdef BULLET_MIRROR_EN
      shadow_dir_q    <= 1'b0;
`endif
    end else if (frame_start) begin
      shadow_x_q      <= BulletX;
      shadow_y_q      <= BulletY;
      shadow_active_q <= bullet_active;
`ifdef BULLET_MIRROR_EN
      shadow_dir_q    <= dir_left;
`endif
    end
  end

  // Stage 1: register the ROM address on a hit (otherwise hold) and the pixel tags.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      s1_valid_q   <= 1'b0;
      s1_hit_q     <= 1'b0;
    end else begin
      if (hit) begin
        read_address <= addr_next;
      end
      s1_valid_q <= pix_valid;
      s1_hit_q   <= hit;
    end
  end

  // Stage 2: delay the tags while the ROM registers its data.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_valid_q <= 1'b0;
      s2_hit_q   <= 1'b0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_hit_q   <= s1_hit_q;
    end
  end

  // Stage 3: registered pixel outputs; transparent or outside pixels report TRANSPARENT_IDX.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_out_valid <= 1'b0;
      bullet_on     <= 1'b0;
      palette_idx   <= TRANSPARENT_IDX;
    end else begin
      pix_out_valid <= s2_valid_q;
      bullet_on     <= bullet_on_next;
      palette_idx   <= bullet_on_next ? rom_data : TRANSPARENT_IDX;
    end
  end

  // Count opaque outputs; frame_start publishes the count and restarts with this cycle's pixel.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      counter_q    <= '0;
      opaque_count <= '0;
    end else if (frame_start) begin
      opaque_count <= counter_q;
      counter_q    <= bullet_on_next ? 16'd1 : 16'd0;
    end else if (bullet_on_next && (counter_q != 16'hFFFF)) begin
      counter_q <= counter_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_bullet_sprite_reader.sv
// Self-checking bench for bullet_sprite_reader: directed scenarios followed by a randomized
// phase, all compared every cycle against a pixel-level reference model and a ROM array.
module tb_bullet_sprite_reader;

  localparam int SW = 20;
  localparam int SH = 20;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        frame_start = 1'b0;
  logic        pix_valid = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  BulletX = '0;
  logic [9:0]  BulletY = '0;
  logic        bullet_active = 1'b0;
  logic        dir_left = 1'b0;
  logic [18:0] read_address;
  logic [3:0]  rom_data = '0;
  logic        pix_out_valid;
  logic        bullet_on;
  logic [3:0]  palette_idx;
  logic [15:0] opaque_count;

  bullet_sprite_reader dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .bullet_active(bullet_active),
    .dir_left     (dir_left),
    .read_address (read_address),
    .rom_data     (rom_data),
    .pix_out_valid(pix_out_valid),
    .bullet_on    (bullet_on),
    .palette_idx  (palette_idx),
    .opaque_count (opaque_count)
  );

  always #5 Clk = ~Clk;

  // Sprite ROM with one cycle of read latency.
  logic [3:0] rom [0:SW*SH-1];
  always @(posedge Clk) begin
    if (int'(read_address) < SW * SH) rom_data <= rom[int'(read_address)];
    else rom_data <= 4'h0;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: one record per presented pixel, emerging two edges after it is sampled.
  typedef struct {
    bit       v;
    bit       on;
    bit [3:0] idx;
  } pix_t;

  pix_t pipe0, pipe1, out_e;
  int   m_sx, m_sy, m_addr, m_cnt, m_oc;
  bit   m_act, m_dir;

  task automatic model_reset();
    pipe0 = '{v: 0, on: 0, idx: 0};
    pipe1 = pipe0;
    out_e = pipe0;
    m_sx = 0; m_sy = 0; m_act = 0; m_dir = 0;
    m_addr = 0; m_cnt = 0; m_oc = 0;
  endtask

  task automatic model_edge();
    int   dx, dy, col, a;
    bit   hit;
    pix_t n;
    dx  = int'(DrawX);
    dy  = int'(DrawY);
    hit = m_act && dx >= m_sx && dx < m_sx + SW && dy >= m_sy && dy < m_sy + SH;
    col = dx - m_sx;
`ifdef BULLET_MIRROR_EN
    if (m_dir) col = SW - 1 - col;
`endif
    a = (dy - m_sy) * SW + col;
    if (hit) m_addr = a;
    n.v   = pix_valid;
    n.on  = pix_valid && hit && (rom[a] != 4'h0);
    n.idx = n.on ? rom[a] : 4'h0;
    out_e = pipe1;
    pipe1 = pipe0;
    pipe0 = n;
    if (frame_start) begin
      m_oc  = m_cnt;
      m_cnt = out_e.on ? 1 : 0;
      m_sx  = int'(BulletX);
      m_sy  = int'(BulletY);
      m_act = bullet_active;
      m_dir = dir_left;
    end else if (out_e.on && m_cnt < 65535) begin
      m_cnt++;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output against the model.
  task automatic cyc(input bit fs, input bit pv, input int dx, input int dy);
    frame_start = fs;
    pix_valid   = pv;
    DrawX       = 10'(dx);
    DrawY       = 10'(dy);
    @(posedge Clk);
    #1;
    model_edge();
    chk("read_address", 32'(read_address), 32'(m_addr));
    chk("pix_out_valid", 32'(pix_out_valid), 32'(out_e.v));
    chk("bullet_on", 32'(bullet_on), 32'(out_e.on));
    chk("palette_idx", 32'(palette_idx), 32'(out_e.idx));
    chk("opaque_count", 32'(opaque_count), 32'(m_oc));
  endtask

  task automatic set_bullet(input int x, input int y, input bit act, input bit dir);
    BulletX       = 10'(x);
    BulletY       = 10'(y);
    bullet_active = act;
    dir_left      = dir;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(read_address), 32'd0);
    chk({tag, "_valid"}, 32'(pix_out_valid), 32'd0);
    chk({tag, "_on"}, 32'(bullet_on), 32'd0);
    chk({tag, "_idx"}, 32'(palette_idx), 32'd0);
    chk({tag, "_count"}, 32'(opaque_count), 32'd0);
  endtask

  initial begin
    int n, idx, zero_idx, cx, cy;

    // ROM with exactly 37 opaque entries.
    for (int i = 0; i < SW * SH; i++) rom[i] = 4'h0;
    n = 0;
    while (n < 37) begin
      idx = int'($urandom_range(0, SW * SH - 1));
      if (rom[idx] == 4'h0) begin
        rom[idx] = 4'($urandom_range(1, 15));
        n++;
      end
    end
    zero_idx = 0;
    while (rom[zero_idx] != 4'h0) zero_idx++;

    // Power-on reset.
    model_reset();
    #2 Reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Hit and address: box at (100,50), pixel (105,53) -> address 65.
    set_bullet(100, 50, 1'b1, 1'b0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 105, 53);
    chk("hit_addr65", 32'(read_address), 32'd65);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("hit_valid", 32'(pix_out_valid), 32'd1);
    chk("hit_idx", 32'(palette_idx), 32'(rom[65]));

    // Box edges.
    cyc(0, 1, 99, 55);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("edge_left", 32'(bullet_on), 32'd0);
    cyc(0, 1, 120, 55);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("edge_right", 32'(bullet_on), 32'd0);
    cyc(0, 1, 119, 69);
    chk("edge_addr399", 32'(read_address), 32'd399);

    // Transparent entry inside the box.
    cyc(0, 1, 100 + zero_idx % SW, 50 + zero_idx / SW);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("transparent_on", 32'(bullet_on), 32'd0);
    chk("transparent_idx", 32'(palette_idx), 32'd0);

    // Shadow: mid-frame BulletX change is ignored until frame_start.
    set_bullet(200, 50, 1'b1, 1'b0);
    cyc(0, 1, 105, 52);
    chk("shadow_old", 32'(read_address), 32'd45);
    cyc(1, 1, 105, 50);
    chk("shadow_fs_pixel", 32'(read_address), 32'd5);
    cyc(0, 1, 205, 51);
    chk("shadow_new", 32'(read_address), 32'd25);

    // Right screen edge: box at 1010 extends past 1023 without wrapping.
    set_bullet(1010, 50, 1'b1, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1020, 50);
    chk("nowrap_addr", 32'(read_address), 32'd10);
    cyc(0, 1, 5, 50);
    chk("nowrap_hold", 32'(read_address), 32'd10);

    // Mirror: left edge of the box reads the last column when flipped.
    set_bullet(100, 50, 1'b1, 1'b1);
    cyc(1, 0, 0, 0);
    cyc(0, 1, 100, 50);
`ifdef BULLET_MIRROR_EN
    chk("mirror_addr", 32'(read_address), 32'd19);
`else
    chk("mirror_addr", 32'(read_address), 32'd0);
`endif

    // Full-sprite scan: 37 opaque pixels published at the next frame_start.
    set_bullet(100, 50, 1'b1, 1'b0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    for (int y = 0; y < SH; y++) begin
      for (int x = 0; x < SW; x++) cyc(0, 1, 100 + x, 50 + y);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("count37", 32'(opaque_count), 32'd37);

    // Reset mid-stream drops in-flight pixels.
    cyc(0, 1, 101, 51);
    cyc(0, 1, 102, 51);
    Reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    model_reset();
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("midreset_t1", 32'(pix_out_valid), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("midreset_t3", 32'(pix_out_valid), 32'd1);

    // Randomized scanning around the latched box with occasional state changes and a reset.
    for (int t = 0; t < 3000; t++) begin
      if (t % 200 == 0) begin
        set_bullet(($urandom_range(0, 3) == 0) ? int'($urandom_range(1000, 1023))
                                               : int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)),
                   $urandom_range(0, 4) != 0, 1'($urandom_range(0, 1)));
      end
      if (t == 1500) begin
        Reset_n = 1'b0;
        #1 check_reset_outputs("rndreset");
        model_reset();
        @(posedge Clk);
        #1 Reset_n = 1'b1;
      end
      cx = m_sx + int'($urandom_range(0, SW + 7)) - 4;
      cy = m_sy + int'($urandom_range(0, SH + 7)) - 4;
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 3) != 0, cx, cy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
